// File: rtl/ucie_ctl_phy_rx_buffer.sv
// Show-ahead receive FIFO between the RDI link and the FDI adapter port.
// Optional per-byte even-parity checking is enabled with `define UCIE_CTL_RX_PARITY_EN.
module ucie_ctl_phy_rx_buffer #(
  parameter int NBYTES    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [3:0]                   i_rdi_pl_state_sts,
  input  logic [NBYTES*8-1:0]          i_data_received,
  input  logic                         i_data_valid,
  input  logic [NBYTES-1:0]            i_data_parity,
  input  logic                         i_fdi_rdy,
  input  logic                         i_flush,
  output logic [NBYTES*8-1:0]          o_fdi_data,
  output logic                         o_fdi_data_valid,
  output logic [$clog2(DEPTH):0]       o_fill_level,
  output logic                         o_almost_full,
  output logic                         o_overflow_detected,
  output logic                         o_parity_error
);

  localparam int W  = NBYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  typedef enum logic [3:0] {
    RDI_RESET  = 4'b0000,
    RDI_ACTIVE = 4'b0001
  } rdi_state_e;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] rd_nxt, wr_nxt;
  logic [CW-1:0] count, count_nxt, residual;
  logic [W-1:0]  data_q, head_nxt;
  logic          afull_q;
  logic          ovf_q;

  logic link_active;
  logic flush_now;
  logic rd_valid;
  logic pop;
  logic beat_in;
  logic full;
  logic push;
  logic drop;

  always_comb begin
    link_active = (i_rdi_pl_state_sts == RDI_ACTIVE);
    flush_now   = i_flush | (i_rdi_pl_state_sts == RDI_RESET);
    rd_valid    = (count != '0) & link_active & ~i_flush;
    pop         = rd_valid & i_fdi_rdy;
    beat_in     = i_data_valid & link_active & ~i_flush;
    full        = (count == DEPTH_C);
    push        = beat_in & (~full | pop);
    drop        = beat_in & full & ~pop;
  end

  always_comb begin
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = count;
    if (pop) begin
      rd_nxt = rd_ptr + AW'(1);
    end
    if (push) begin
      wr_nxt = wr_ptr + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Head register: an existing entry stays at the head unless the FIFO would
  // be empty after the pop, in which case the incoming beat bypasses storage.
  always_comb begin
    residual = count - CW'(pop);
    head_nxt = data_q;
    if (residual != '0) begin
      head_nxt = mem[rd_nxt];
    end else if (push) begin
      head_nxt = i_data_received;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data_received;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else if (flush_now) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rd_ptr  <= rd_nxt;
      wr_ptr  <= wr_nxt;
      count   <= count_nxt;
      afull_q <= (count_nxt >= AFULL_C);
      data_q  <= head_nxt;
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef UCIE_CTL_RX_PARITY_EN
  logic [NBYTES-1:0] byte_err;
  logic              perr_q;

  always_comb begin
    byte_err = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      byte_err[b] = ^{i_data_received[b*8 +: 8], i_data_parity[b]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perr_q <= 1'b0;
    end else if (flush_now) begin
      perr_q <= 1'b0;
    end else if (push && (byte_err != '0)) begin
      perr_q <= 1'b1;
    end
  end

  assign o_parity_error = perr_q;
`else
  logic unused_parity;
  assign unused_parity  = ^i_data_parity;
  assign o_parity_error = 1'b0;
`endif

  assign o_fdi_data          = data_q;
  assign o_fdi_data_valid    = rd_valid;
  assign o_fill_level        = count;
  assign o_almost_full       = afull_q;
  assign o_overflow_detected = ovf_q;

endmodule

// File: tb/tb_ucie_ctl_phy_rx_buffer.sv
// Scoreboard bench for ucie_ctl_phy_rx_buffer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_ucie_ctl_phy_rx_buffer;

  localparam int NBYTES    = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = 12;
  localparam int W         = NBYTES * 8;

  localparam logic [3:0] ST_RESET  = 4'b0000;
  localparam logic [3:0] ST_ACTIVE = 4'b0001;
  localparam logic [3:0] ST_OTHER  = 4'b0011;

  logic              i_clk;
  logic              i_rst_n;
  logic [3:0]        i_rdi_pl_state_sts;
  logic [W-1:0]      i_data_received;
  logic              i_data_valid;
  logic [NBYTES-1:0] i_data_parity;
  logic              i_fdi_rdy;
  logic              i_flush;
  logic [W-1:0]      o_fdi_data;
  logic              o_fdi_data_valid;
  logic [$clog2(DEPTH):0] o_fill_level;
  logic              o_almost_full;
  logic              o_overflow_detected;
  logic              o_parity_error;

  ucie_ctl_phy_rx_buffer #(
    .NBYTES(NBYTES),
    .DEPTH(DEPTH),
    .AFULL_LVL(AFULL_LVL)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_rdi_pl_state_sts(i_rdi_pl_state_sts),
    .i_data_received(i_data_received),
    .i_data_valid(i_data_valid),
    .i_data_parity(i_data_parity),
    .i_fdi_rdy(i_fdi_rdy),
    .i_flush(i_flush),
    .o_fdi_data(o_fdi_data),
    .o_fdi_data_valid(o_fdi_data_valid),
    .o_fill_level(o_fill_level),
    .o_almost_full(o_almost_full),
    .o_overflow_detected(o_overflow_detected),
    .o_parity_error(o_parity_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [W-1:0] exp_q[$];
  bit  m_ovf;
  bit  m_perr;
  int  total = 0;
  int  bad   = 0;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [NBYTES-1:0] good_par(input logic [W-1:0] d);
    logic [NBYTES-1:0] p;
    for (int b = 0; b < NBYTES; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  // Reference model: applies pushes, drops and flushes at each clock edge.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end else if (i_flush || i_rdi_pl_state_sts == ST_RESET) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end else if (i_data_valid && i_rdi_pl_state_sts == ST_ACTIVE) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(i_data_received);
`ifdef UCIE_CTL_RX_PARITY_EN
        if (i_data_parity != good_par(i_data_received)) m_perr = 1'b1;
`endif
      end else begin
        m_ovf = 1'b1;
      end
    end
  end

  // Monitor: checks status every cycle and pops the scoreboard on each handshake.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      bit exp_valid;
      exp_valid = (exp_q.size() > 0) && (i_rdi_pl_state_sts == ST_ACTIVE) && !i_flush;
      chk("fill_level", W'(o_fill_level), W'(exp_q.size()));
      chk("data_valid", W'(o_fdi_data_valid), W'(exp_valid));
      chk("almost_full", W'(o_almost_full), W'(exp_q.size() >= AFULL_LVL));
      chk("overflow", W'(o_overflow_detected), W'(m_ovf));
      chk("parity_error", W'(o_parity_error), W'(m_perr));
      if (exp_valid) begin
        chk("head_data", o_fdi_data, exp_q[0]);
        if (i_fdi_rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy,
                       input logic [3:0] st, input bit fl, input bit badpar);
    i_data_valid       = v;
    i_data_received    = d;
    i_data_parity      = good_par(d) ^ (badpar ? NBYTES'(1) : NBYTES'(0));
    i_fdi_rdy          = rdy;
    i_rdi_pl_state_sts = st;
    i_flush            = fl;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, o_fdi_data, '0);
    chk({tag, "_valid"}, W'(o_fdi_data_valid), '0);
    chk({tag, "_fill"}, W'(o_fill_level), '0);
    chk({tag, "_afull"}, W'(o_almost_full), '0);
    chk({tag, "_ovf"}, W'(o_overflow_detected), '0);
    chk({tag, "_perr"}, W'(o_parity_error), '0);
  endtask

  initial begin
    i_rst_n            = 1'b0;
    i_rdi_pl_state_sts = ST_RESET;
    i_data_received    = '0;
    i_data_valid       = 1'b0;
    i_data_parity      = '0;
    i_fdi_rdy          = 1'b0;
    i_flush            = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    drive(0, '0, 0, ST_ACTIVE, 0, 0);

    // Streaming with ready held high: fill never exceeds one.
    for (int k = 1; k <= 4; k++) drive(1, W'(k), 1, ST_ACTIVE, 0, 0);
    repeat (3) drive(0, '0, 1, ST_ACTIVE, 0, 0);

    // Fill past capacity, then drain.
    for (int k = 1; k <= 17; k++) drive(1, W'(k), 0, ST_ACTIVE, 0, 0);
    repeat (18) drive(0, '0, 1, ST_ACTIVE, 0, 0);

    // Full FIFO with simultaneous push and pop.
    for (int k = 1; k <= 16; k++) drive(1, W'(32'h100 + k), 0, ST_ACTIVE, 0, 0);
    drive(1, W'(32'haaa), 1, ST_ACTIVE, 0, 0);
    drive(0, '0, 0, ST_ACTIVE, 0, 0);
    repeat (17) drive(0, '0, 1, ST_ACTIVE, 0, 0);

    // Link leaves Active mid-stream; incoming beats are dropped silently.
    for (int k = 1; k <= 5; k++) drive(1, W'(32'h200 + k), 0, ST_ACTIVE, 0, 0);
    for (int k = 0; k < 10; k++) drive(1, W'(32'h300 + k), 1, ST_OTHER, 0, 0);
    repeat (6) drive(0, '0, 1, ST_ACTIVE, 0, 0);
    for (int k = 1; k <= 3; k++) drive(1, W'(32'h400 + k), 0, ST_ACTIVE, 0, 0);
    repeat (2) drive(0, '0, 0, ST_RESET, 0, 0);
    drive(0, '0, 0, ST_ACTIVE, 0, 0);

    // Bad-parity beat is still delivered.
    drive(1, W'(64'h0123_4567_89ab_cd01), 0, ST_ACTIVE, 0, 1);
    drive(0, '0, 0, ST_ACTIVE, 0, 0);
    drive(0, '0, 1, ST_ACTIVE, 0, 0);
    drive(0, '0, 0, ST_ACTIVE, 0, 0);

    // Flush overriding a simultaneous push and pop.
    for (int k = 1; k <= 4; k++) drive(1, W'(32'h500 + k), 0, ST_ACTIVE, 0, 0);
    drive(1, W'(32'h5ff), 1, ST_ACTIVE, 1, 0);
    drive(1, W'(32'h600), 0, ST_ACTIVE, 0, 0);
    drive(0, '0, 1, ST_ACTIVE, 0, 0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] st;
      logic [W-1:0] d;
      if ($urandom_range(0, 19) < 17) st = ST_ACTIVE;
      else if ($urandom_range(0, 4) == 0) st = ST_RESET;
      else st = 4'($urandom_range(2, 15));
      d = {$urandom, $urandom};
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 7),
            st, $urandom_range(0, 59) == 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset between clock edges in the middle of a burst.
    for (int k = 1; k <= 6; k++) drive(1, W'(32'h700 + k), (k > 3), ST_ACTIVE, 0, (k == 2));
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) drive(1, W'(32'h800 + k), 1, ST_ACTIVE, 0, 0);
    repeat (3) drive(0, '0, 1, ST_ACTIVE, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
